// File: rtl/pulse_train_pkg.sv
// pulse_train_pkg -- shared types and parameter defaults for pulse_train_gen.
//   state_t            : FSM state encoding (IDLE, HIGH, LOW, GAP)
//   TICK_DIV_DEFAULT   : clk cycles per tick (250 ms at 50 MHz)
//   CNT_W_DEFAULT      : width of the pulses/sets operands and counters
//   GAP_TICKS_DEFAULT  : low gap between sets, in ticks
package pulse_train_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int TICK_DIV_DEFAULT  = 12500000;
  localparam int CNT_W_DEFAULT     = 3;
  localparam int GAP_TICKS_DEFAULT = 4;

endpackage

// File: rtl/pulse_train_gen_tick_timer.sv
// tick_timer -- free-running tick divider.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   clear   : synchronous restart; counter is 0 on the following cycle
//   tick    : high for one cycle while the counter sits at TICK_DIV-1
module tick_timer
  import pulse_train_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen -- generates `sets` groups of `pulses` one-tick-high /
// one-tick-low pulses, separated by GAP_TICKS ticks of low gap.
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   trigger   : start request, rising-edge sensitive
//   abort     : synchronous level, cancels the train (no done)
//   pulses    : pulses per set (0 = ignore start)
//   sets      : number of sets (0 = ignore start)
//   repeat_en : (only with PULSE_TRAIN_REPEAT_EN) restart the train after a
//               gap instead of returning to IDLE
//   pulse     : registered pulse-train output
//   busy      : high whenever the FSM is not IDLE
//   done      : one-cycle strobe on normal completion
// Optional feature macro: PULSE_TRAIN_REPEAT_EN.
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter int GAP_TICKS = GAP_TICKS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             trigger,
  input  logic             abort,
  input  logic [CNT_W-1:0] pulses,
  input  logic [CNT_W-1:0] sets,
`ifdef PULSE_TRAIN_REPEAT_EN
  input  logic             repeat_en,
`endif
  output logic             pulse,
  output logic             busy,
  output logic             done
);

  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

  state_t           state, state_nxt;
  logic             trig_prev;
  logic             trig_edge;
  logic             tick;
  logic             start;
  logic             done_nxt;
  logic [CNT_W-1:0] pulses_lat, pulses_lat_nxt;
  logic [CNT_W-1:0] sets_lat, sets_lat_nxt;
  logic [CNT_W-1:0] pulse_left, pulse_left_nxt;
  logic [CNT_W-1:0] set_left, set_left_nxt;
  logic [GW-1:0]    gap_cnt, gap_cnt_nxt;

  assign trig_edge = trigger & ~trig_prev;
  assign busy      = (state != IDLE);

  // Restarting the divider on every start keeps each state a whole number
  // of ticks measured from the trigger edge.
  tick_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (start),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      // Held at 1 so a trigger already high at reset release is not an edge.
      trig_prev  <= 1'b1;
      pulse      <= 1'b0;
      done       <= 1'b0;
      pulses_lat <= '0;
      sets_lat   <= '0;
      pulse_left <= '0;
      set_left   <= '0;
      gap_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      trig_prev  <= trigger;
      pulse      <= (state_nxt == HIGH);
      done       <= done_nxt;
      pulses_lat <= pulses_lat_nxt;
      sets_lat   <= sets_lat_nxt;
      pulse_left <= pulse_left_nxt;
      set_left   <= set_left_nxt;
      gap_cnt    <= gap_cnt_nxt;
    end
  end

  // Counters hold "remaining including the current one" and are only
  // decremented while greater than 1, so they can never wrap.
  always_comb begin
    state_nxt      = state;
    start          = 1'b0;
    done_nxt       = 1'b0;
    pulses_lat_nxt = pulses_lat;
    sets_lat_nxt   = sets_lat;
    pulse_left_nxt = pulse_left;
    set_left_nxt   = set_left;
    gap_cnt_nxt    = gap_cnt;

    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (trig_edge && (pulses != '0) && (sets != '0)) begin
            start          = 1'b1;
            pulses_lat_nxt = pulses;
            sets_lat_nxt   = sets;
            pulse_left_nxt = pulses;
            set_left_nxt   = sets;
            state_nxt      = HIGH;
          end
        end
        HIGH: begin
          if (tick) begin
            state_nxt = LOW;
          end
        end
        LOW: begin
          if (tick) begin
            if (pulse_left > CNT_W'(1)) begin
              pulse_left_nxt = pulse_left - CNT_W'(1);
              state_nxt      = HIGH;
            end else if (set_left > CNT_W'(1)) begin
              set_left_nxt   = set_left - CNT_W'(1);
              pulse_left_nxt = pulses_lat;
              gap_cnt_nxt    = '0;
              state_nxt      = GAP;
            end else begin
              done_nxt = 1'b1;
`ifdef PULSE_TRAIN_REPEAT_EN
              if (repeat_en) begin
                pulse_left_nxt = pulses_lat;
                set_left_nxt   = sets_lat;
                gap_cnt_nxt    = '0;
                state_nxt      = GAP;
              end else begin
                state_nxt = IDLE;
              end
`else
              state_nxt = IDLE;
`endif
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (gap_cnt == GAP_LAST) begin
              state_nxt = HIGH;
            end else begin
              gap_cnt_nxt = gap_cnt + GW'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
module tb_pulse_train_gen;

  localparam int TICK_DIV  = 4;
  localparam int CNT_W     = 3;
  localparam int GAP_TICKS = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             trigger;
  logic             abort;
  logic [CNT_W-1:0] pulses;
  logic [CNT_W-1:0] sets;
`ifdef PULSE_TRAIN_REPEAT_EN
  logic             repeat_en;
`endif
  logic             pulse;
  logic             busy;
  logic             done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pulse_train_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W),
    .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .trigger  (trigger),
    .abort    (abort),
    .pulses   (pulses),
    .sets     (sets),
`ifdef PULSE_TRAIN_REPEAT_EN
    .repeat_en(repeat_en),
`endif
    .pulse    (pulse),
    .busy     (busy),
    .done     (done)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    trigger = 1'b0;
    abort   = 1'b0;
    pulses  = '0;
    sets    = '0;
`ifdef PULSE_TRAIN_REPEAT_EN
    repeat_en = 1'b0;
`endif
    #2;
    tests++;
    if ({pulse, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL reset_hold: {pulse,busy,done}=%b expected 000", {pulse, busy, done});
    end
    step(); step();
    reset_n = 1'b1;
    step();
    tests++;
    if ({pulse, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL reset_release: {pulse,busy,done}=%b expected 000", {pulse, busy, done});
    end
  endtask

  // 2 pulses x 2 sets: 4H 4L 4H 4L 8L 4H 4L 4H 4L, then one done cycle.
  // Also changes pulses/sets after latching and gives a second trigger edge
  // while busy; neither may alter the pattern.
  task automatic test_basic();
    logic [39:0] pat;
    pat = 40'b1111_0000_1111_0000_0000_0000_1111_0000_1111_0000;
    pulses  = 3'd2;
    sets    = 3'd2;
    trigger = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 0) trigger = 1'b0;
      if (i == 3) begin pulses = 3'd7; sets = 3'd7; end
      if (i == 10) trigger = 1'b1;
      if (i == 12) trigger = 1'b0;
      tests++;
      if ({pulse, busy, done} !== {pat[39-i], 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL basic_pattern cycle %0d: {pulse,busy,done}=%b expected %b",
                 i, {pulse, busy, done}, {pat[39-i], 1'b1, 1'b0});
      end
    end
    step();
    tests++;
    if ({pulse, busy, done} !== 3'b001) begin
      fails++;
      $display("FAIL basic_done: {pulse,busy,done}=%b expected 001", {pulse, busy, done});
    end
    step();
    tests++;
    if ({pulse, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL basic_after_done: {pulse,busy,done}=%b expected 000", {pulse, busy, done});
    end
  endtask

  task automatic test_zero_operands();
    for (int k = 0; k < 2; k++) begin
      pulses  = (k == 0) ? 3'd0 : 3'd3;
      sets    = (k == 0) ? 3'd3 : 3'd0;
      trigger = 1'b1;
      for (int i = 0; i < 12; i++) begin
        step();
        if (i == 1) trigger = 1'b0;
        tests++;
        if ({pulse, busy, done} !== 3'b000) begin
          fails++;
          $display("FAIL zero_operand case %0d cycle %0d: {pulse,busy,done}=%b expected 000",
                   k, i, {pulse, busy, done});
        end
      end
    end
  endtask

  // 7 x 7: 49 pulses, 6 gaps (12 low cycles between sets), one done,
  // 7*7*8 + 6*8 = 440 busy cycles.
  task automatic test_max();
    int   n_pulse, n_gap, n_done, n_busy, low_run;
    logic prev;
    n_pulse = 0; n_gap = 0; n_done = 0; n_busy = 0; low_run = 0; prev = 1'b0;
    pulses  = 3'd7;
    sets    = 3'd7;
    trigger = 1'b1;
    for (int i = 0; i < 470; i++) begin
      step();
      trigger = 1'b0;
      if (busy) n_busy++;
      if (done) n_done++;
      if (pulse && !prev) begin
        n_pulse++;
        if (low_run == 12) n_gap++;
        low_run = 0;
      end else if (!pulse && busy) begin
        low_run++;
      end
      prev = pulse;
    end
    tests++;
    if (n_pulse !== 49) begin
      fails++;
      $display("FAIL max_pulses: got %0d expected 49", n_pulse);
    end
    tests++;
    if (n_gap !== 6) begin
      fails++;
      $display("FAIL max_gaps: got %0d expected 6", n_gap);
    end
    tests++;
    if (n_done !== 1) begin
      fails++;
      $display("FAIL max_done: got %0d expected 1", n_done);
    end
    tests++;
    if (n_busy !== 440) begin
      fails++;
      $display("FAIL max_busy_cycles: got %0d expected 440", n_busy);
    end
  endtask

  task automatic test_abort();
    logic [15:0] pat;
    pat     = 16'b1111_0000_1111_0000;
    pulses  = 3'd2;
    sets    = 3'd1;
    trigger = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      step();
      trigger = 1'b0;
    end
    tests++;
    if (pulse !== 1'b1) begin
      fails++;
      $display("FAIL abort_second_high: pulse=%b expected 1", pulse);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests++;
    if ({pulse, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL abort_next: {pulse,busy,done}=%b expected 000", {pulse, busy, done});
    end
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if ({pulse, busy, done} !== 3'b000) begin
        fails++;
        $display("FAIL abort_idle cycle %0d: {pulse,busy,done}=%b expected 000", i, {pulse, busy, done});
      end
    end
    // Abort wins over a simultaneous trigger edge.
    abort   = 1'b1;
    trigger = 1'b1;
    step();
    abort = 1'b0;
    step();
    trigger = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_vs_trigger: busy=%b expected 0", busy);
    end
    step();
    // Clean restart.
    trigger = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      trigger = 1'b0;
      tests++;
      if ({pulse, busy, done} !== {pat[15-i], 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL abort_restart cycle %0d: {pulse,busy,done}=%b expected %b",
                 i, {pulse, busy, done}, {pat[15-i], 1'b1, 1'b0});
      end
    end
    step();
    tests++;
    if ({pulse, busy, done} !== 3'b001) begin
      fails++;
      $display("FAIL abort_restart_done: {pulse,busy,done}=%b expected 001", {pulse, busy, done});
    end
    step();
  endtask

  task automatic test_back_to_back();
    pulses  = 3'd1;
    sets    = 3'd1;
    trigger = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      trigger = 1'b0;
    end
    step();
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first_done: done=%b expected 1", done);
    end
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    tests++;
    if ({pulse, busy, done} !== 3'b110) begin
      fails++;
      $display("FAIL b2b_restart: {pulse,busy,done}=%b expected 110", {pulse, busy, done});
    end
    for (int i = 1; i < 8; i++) step();
    step();
    tests++;
    if ({pulse, busy, done} !== 3'b001) begin
      fails++;
      $display("FAIL b2b_second_done: {pulse,busy,done}=%b expected 001", {pulse, busy, done});
    end
    step();
  endtask

  task automatic test_reset_trigger();
    logic [7:0] pat;
    pat     = 8'b1111_0000;
    reset_n = 1'b0;
    trigger = 1'b1;
    step(); step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL held_trigger_no_start cycle %0d: busy=%b expected 0", i, busy);
      end
    end
    trigger = 1'b0;
    step();
    pulses  = 3'd2;
    sets    = 3'd1;
    trigger = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      step();
      if (i == 0) trigger = 1'b0;
      if (i == 2) trigger = 1'b1;
      if (i == 3) trigger = 1'b0;
      if (i < 8) begin
        tests++;
        if (pulse !== pat[7-i]) begin
          fails++;
          $display("FAIL busy_edge_ignored cycle %0d: pulse=%b expected %b", i, pulse, pat[7-i]);
        end
      end
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if ({pulse, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL reset_mid_train: {pulse,busy,done}=%b expected 000", {pulse, busy, done});
    end
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      tests++;
      if ({pulse, busy, done} !== 3'b000) begin
        fails++;
        $display("FAIL after_mid_reset cycle %0d: {pulse,busy,done}=%b expected 000", i, {pulse, busy, done});
      end
    end
  endtask

`ifdef PULSE_TRAIN_REPEAT_EN
  // 1 x 1 with repeat: 4H 4L 8L then restart, so a 16-cycle period with
  // done in the first gap cycle; after repeat drops, one more pass ends.
  task automatic test_repeat();
    localparam int PERIOD = (2 + GAP_TICKS) * TICK_DIV;
    pulses    = 3'd1;
    sets      = 3'd1;
    repeat_en = 1'b1;
    trigger   = 1'b1;
    for (int i = 0; i <= 72; i++) begin
      step();
      trigger = 1'b0;
      if (i == 59) repeat_en = 1'b0;
      tests++;
      if (i < 60) begin
        if ({busy, done} !== {1'b1, (i % PERIOD) == 8}) begin
          fails++;
          $display("FAIL repeat cycle %0d: {busy,done}=%b expected %b", i, {busy, done}, {1'b1, (i % PERIOD) == 8});
        end
      end else begin
        if ({busy, done} !== {i < 72, i == 72}) begin
          fails++;
          $display("FAIL repeat_stop cycle %0d: {busy,done}=%b expected %b", i, {busy, done}, {i < 72, i == 72});
        end
      end
    end
    step();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_operands();
    test_max();
    test_abort();
    test_back_to_back();
    test_reset_trigger();
`ifdef PULSE_TRAIN_REPEAT_EN
    test_repeat();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
